// File: rtl/ysyx_22040632_exec_ctrl.sv
// ysyx_22040632_exec_ctrl
// Multi-cycle control FSM for the RV64 integer core. Runs one instruction at
// a time through FETCH -> WAIT -> EXEC -> WB, owns the PC, drives the GPR
// read/write ports and pulses commit_valid once per retired instruction.
// Only ADDI is implemented; any other encoding parks the FSM in HALT with the
// sticky illegal flag raised.
module ysyx_22040632_exec_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction fetch
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  // GPR file
  output logic [4:0]  rf_raddr,
  input  logic [63:0] rf_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  // control / difftest
  input  logic        halt_req,
  output logic        commit_valid,
  output logic [63:0] commit_pc,
  output logic        halted,
  output logic        illegal
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [6:0] OP_IMM     = 7'b0010011;
  localparam logic [2:0] F3_ADDI    = 3'b000;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [63:0] pc;
  logic [31:0] instr;
  logic [63:0] result;
  // Goes high on the first clean posedge after reset release, so no request
  // is raised in the same cycle rst_n deasserts.
  logic        active;

  logic [4:0]  rd;
  logic [63:0] imm;
  logic        is_addi;
  logic        retire;

  assign rd      = instr[11:7];
  assign imm     = {{52{instr[31]}}, instr[31:20]};
  assign is_addi = (instr[6:0] == OP_IMM) && (instr[14:12] == F3_ADDI);
  // EXEC is the only point where the decode decides between WB and HALT.
  assign retire  = (state == S_EXEC) && is_addi;

  // Address outputs come straight from architectural registers.
  assign imem_addr = pc;
  assign rf_raddr  = instr[19:15];
  assign rf_wdata  = result;

  // Fetch request: halt_req is looked at only while sitting in FETCH, and it
  // suppresses the request in the very cycle it is seen.
  assign imem_req_valid = active && (state == S_FETCH) && !halt_req;

  // Next-state decode.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: begin
        if (active) begin
          if (halt_req)            state_nxt = S_HALT;
          else if (imem_req_ready) state_nxt = S_WAIT;
        end
      end
      S_WAIT:  if (imem_rsp_valid) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = is_addi ? S_WB : S_HALT;
      S_WB:    state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_HALT;
    endcase
  end

  // FSM state, PC and latched instruction.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      pc     <= RESET_PC;
      instr  <= 32'h0;
      active <= 1'b0;
    end else begin
      active <= 1'b1;
      state  <= state_nxt;
      // A response outside WAIT is ignored.
      if ((state == S_WAIT) && imem_rsp_valid) instr <= imem_rdata;
      // pc wraps modulo 2^64 naturally.
      if (state == S_WB) pc <= pc + 64'd4;
    end
  end

  // Writeback / commit outputs: loaded on the EXEC->WB edge so they are valid
  // for exactly the WB cycle, and cleared everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= 64'h0;
      rf_we        <= 1'b0;
      rf_waddr     <= 5'h0;
      commit_valid <= 1'b0;
      commit_pc    <= 64'h0;
    end else begin
      result       <= retire ? (rf_rdata + imm) : 64'h0;
      rf_we        <= retire && (rd != 5'd0);
      rf_waddr     <= retire ? rd : 5'h0;
      commit_valid <= retire;
      commit_pc    <= retire ? pc : 64'h0;
    end
  end

  // Status flags: both sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      if (state_nxt == S_HALT)            halted  <= 1'b1;
      if ((state == S_EXEC) && !is_addi)  illegal <= 1'b1;
    end
  end

endmodule
